jk_bank_ctrl: RTL and testbench

Command-driven sequencer for a bank of `WIDTH` `jk_ff` flip-flops. It accepts one command at a time over a valid/ready handshake and drives each flip-flop's J/K pins for a programmed number of clock edges. Each command applies one of four operations (hold, clear, set, toggle) to the bits selected by a mask. It sits between a register-programming master and the flip-flop bank, and is the only agent that drives the bank's J/K inputs.

---
 rtl/jk_bank_ctrl.sv | 122 ++++++++++++
 tb/tb_jk_bank_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flops. It accepts one masked
// hold/clear/set/toggle command at a time and applies it for a programmed number of edges.

module jk_ff (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
      unique case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

module jk_bank_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] j_vec, k_vec;
  logic             accept;

  assign cmd_ready = (state == S_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt     = S_APPLY;
          remaining_nxt = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
        end
      end
      S_APPLY: begin
        remaining_nxt = remaining - CNT_W'(1);
        // A count of one or less means this edge is the last active edge.
        if (remaining <= CNT_W'(1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      op_r      <= '0;
      mask_r    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      if (accept) begin
        op_r   <= cmd_op;
        mask_r <= cmd_mask;
      end
      // Outputs are registered from the next state so that they line up with the state register.
      busy <= (state_nxt != S_IDLE);
      done <= (state_nxt == S_DONE);
    end
  end

  // The op code's upper bit is J and its lower bit is K. Only APPLY drives the bank.
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (state == S_APPLY) begin
      j_vec = mask_r & {WIDTH{op_r[1]}};
      k_vec = mask_r & {WIDTH{op_r[0]}};
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    jk_ff u_ff (
      .clk  (clk),
      .reset(reset),
      .j    (j_vec[i]),
      .k    (k_vec[i]),
      .q    (q[i])
    );
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl. It uses a table of commands and hand-written corner
// sequences. Final bank values go through a scoreboard queue that is checked on each done pulse.

module tb_jk_bank_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam logic [1:0] OP_HOLD = 2'b00, OP_CLEAR = 2'b01, OP_SET = 2'b10, OP_TOGGLE = 2'b11;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_mask (cmd_mask),
    .cmd_count(cmd_count),
    .q        (q),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb_q[$];

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] exp_q;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expected bank value.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("sb_q_final", q, sb_q.pop_front());
      end
    end
  end

  // Called on a negedge. Returns on the negedge right after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] mask,
                      input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] exp_q);
    int n = 0;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_count = cnt;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", cmd_ready, 1);
    sb_q.push_back(exp_q);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic post_idle();
    @(negedge clk);
    check("post_done_low", done, 0);
    check("post_busy_low", busy, 0);
    check("post_ready_high", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int exp_lat;
    int dn;
    logic [WIDTH-1:0] traj[3];

    vecs[0] = '{OP_TOGGLE, 8'h01, 4'd0,  8'hAB};
    vecs[1] = '{OP_CLEAR,  8'h80, 4'd2,  8'h2B};
    vecs[2] = '{OP_SET,    8'hF0, 4'd15, 8'hFB};
    vecs[3] = '{OP_HOLD,   8'hFF, 4'd2,  8'hFB};
    vecs[4] = '{OP_TOGGLE, 8'hFF, 4'd2,  8'hFB};
    vecs[5] = '{OP_TOGGLE, 8'h0F, 4'd5,  8'hF4};
    vecs[6] = '{OP_CLEAR,  8'hFF, 4'd1,  8'h00};
    vecs[7] = '{OP_SET,    8'h3C, 4'd1,  8'h3C};
    traj[0] = 8'hAA;
    traj[1] = 8'hA5;
    traj[2] = 8'hAA;

    // Reset is held with a valid command pending, which must not be accepted.
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_SET;
    cmd_mask  = 8'hFF;
    cmd_count = 4'd1;
    repeat (2) begin
      @(negedge clk);
      check("rst_ready_low", cmd_ready, 0);
      check("rst_busy_low", busy, 0);
      check("rst_q_zero", q, 8'h00);
    end
    reset     = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("rel_ready_high", cmd_ready, 1);
    check("rel_done_low", done, 0);
    @(negedge clk);
    check("rel_q_zero", q, 8'h00);
    check("rel_busy_low", busy, 0);

    // SET A5, count 1.
    send(OP_SET, 8'hA5, 4'd1, 8'hA5);
    check("set_busy_t0", busy, 1);
    check("set_q_t0", q, 8'h00);
    @(negedge clk);
    check("set_q_t1", q, 8'hA5);
    check("set_done_t1", done, 1);
    post_idle();

    // TOGGLE 0F, count 3: the bank value is checked after each edge.
    send(OP_TOGGLE, 8'h0F, 4'd3, 8'hAA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tog_traj_q", q, traj[i]);
      check("tog_traj_done", done, (i == 2) ? 1 : 0);
    end
    post_idle();

    // Table of commands. The latency from the accepting edge to done equals max(count,1).
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].op, vecs[v].mask, vecs[v].cnt, vecs[v].exp_q);
      wait_done(lat);
      exp_lat = (vecs[v].cnt == 0) ? 1 : int'(vecs[v].cnt);
      check("vec_latency", lat, exp_lat);
      check("vec_q", q, vecs[v].exp_q);
      post_idle();
    end

    // HOLD 4 as a timed wait. A second command is held valid during busy.
    send(OP_HOLD, 8'hFF, 4'd4, 8'h3C);
    cmd_op    = OP_SET;
    cmd_mask  = 8'h01;
    cmd_count = 4'd1;
    cmd_valid = 1'b1;
    sb_q.push_back(8'h3D);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_busy", busy, 1);
      check("hold_q", q, 8'h3C);
      check("hold_ready_low", cmd_ready, 0);
      check("hold_done", done, (i == 4) ? 1 : 0);
    end
    @(negedge clk);
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_ready", cmd_ready, 1);
    @(negedge clk);
    check("b2b_accepted", busy, 1);
    cmd_valid = 1'b0;
    wait_done(lat);
    check("b2b_latency", lat, 1);
    check("b2b_q", q, 8'h3D);
    post_idle();

    // Reset lands on the 3rd APPLY edge of TOGGLE FF, count 8.
    send(OP_TOGGLE, 8'hFF, 4'd8, 8'h00);
    @(negedge clk);
    check("mid_q_t1", q, 8'hC2);
    @(negedge clk);
    check("mid_q_t2", q, 8'h3D);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", cmd_ready, 0);
    reset = 1'b0;
    #1;
    check("mid_rel_ready", cmd_ready, 1);
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      dn += int'(done);
    end
    check("mid_no_done", dn, 0);
    check("mid_idle_busy", busy, 0);

    // Recovery after the abandoned command.
    send(OP_SET, 8'h81, 4'd3, 8'h81);
    wait_done(lat);
    check("rec_latency", lat, 3);
    post_idle();

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
